// File: rtl/sar_scan_control.sv
// Successive-approximation ADC controller with a channel-mask scan sequencer.
// Produces one tagged result per enabled channel and supports single scans,
// continuous scans and a synchronous abort.
module sar_scan_control #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned SETTLE   = 4,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned CH_BITS  = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                go,
  input  logic [CHANNELS-1:0] ch_mask,
  input  logic                continuous,
  input  logic                abort,
  input  logic                cmp,
  output logic [WIDTH-1:0]    value,
  output logic                sample,
  output logic [CH_BITS-1:0]  channel,
  output logic                busy,
  output logic [WIDTH-1:0]    result,
  output logic [CH_BITS-1:0]  result_ch,
  output logic                valid,
  output logic                done
);

  localparam int unsigned CNT_W = $clog2(SETTLE + 1);
  localparam logic [WIDTH-1:0] MSB = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_SAMPLE, S_CONVERT, S_STORE} state_e;

  state_e              state_q, state_d;
  logic                go_q, go_d;
  logic [CHANNELS-1:0] mask_q, mask_d;
  logic [CH_BITS-1:0]  next_ch_q, next_ch_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]    pos_q, pos_d;
  logic [WIDTH-1:0]    value_q, value_d;
  logic                sample_q, sample_d;
  logic [CH_BITS-1:0]  channel_q, channel_d;
  logic                busy_q, busy_d;
  logic [WIDTH-1:0]    result_q, result_d;
  logic [CH_BITS-1:0]  result_ch_q, result_ch_d;
  logic                valid_q, valid_d;
  logic                done_q, done_d;

  logic                start_c;
  logic                higher_found_c;
  logic [CH_BITS-1:0]  higher_ch_c;
  logic [WIDTH-1:0]    trial_c;

  // Index of the lowest set bit of a channel mask (0 when empty).
  function automatic logic [CH_BITS-1:0] lowest_ch(input logic [CHANNELS-1:0] m);
    lowest_ch = '0;
    for (int i = int'(CHANNELS) - 1; i >= 0; i--) begin
      if (m[i]) lowest_ch = CH_BITS'(i);
    end
  endfunction

  assign start_c = go & ~go_q;

  // Next enabled channel above the one currently converting.
  always_comb begin
    higher_found_c = 1'b0;
    higher_ch_c    = '0;
    for (int i = int'(CHANNELS) - 1; i >= 0; i--) begin
      if (mask_q[i] && (i > int'(channel_q))) begin
        higher_found_c = 1'b1;
        higher_ch_c    = CH_BITS'(i);
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic; abort from any active state wins over everything.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (!abort && start_c && (ch_mask != '0)) state_d = S_SAMPLE;
      S_SAMPLE:  if (abort) state_d = S_IDLE;
                 else if (cnt_q == CNT_W'(1)) state_d = S_CONVERT;
      S_CONVERT: if (abort) state_d = S_IDLE;
                 else if (pos_q[0]) state_d = S_STORE;
      S_STORE:   if (abort || done_q) state_d = S_IDLE;
                 else state_d = S_SAMPLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Datapath and registered outputs for the chosen transition.
  always_comb begin
    go_d        = go;
    mask_d      = mask_q;
    next_ch_d   = next_ch_q;
    cnt_d       = cnt_q;
    pos_d       = pos_q;
    value_d     = value_q;
    sample_d    = sample_q;
    channel_d   = channel_q;
    result_d    = result_q;
    result_ch_d = result_ch_q;
    valid_d     = 1'b0;
    done_d      = 1'b0;
    busy_d      = (state_d != S_IDLE);
    trial_c     = value_q;

    unique case (state_q)
      S_IDLE: begin
        if (state_d == S_SAMPLE) begin
          mask_d    = ch_mask;
          channel_d = lowest_ch(ch_mask);
          value_d   = MSB;
          pos_d     = MSB;
          sample_d  = 1'b1;
          cnt_d     = CNT_W'(SETTLE);
        end
      end
      S_SAMPLE: begin
        if (state_d == S_CONVERT) sample_d = 1'b0;
        else                      cnt_d    = cnt_q - CNT_W'(1);
      end
      S_CONVERT: begin
        // Resolve the current trial bit, then raise the next one.
        if (cmp) trial_c = trial_c & ~pos_q;
        pos_d   = pos_q >> 1;
        trial_c = trial_c | pos_d;
        value_d = trial_c;
        if (state_d == S_STORE) begin
          result_d    = trial_c;
          result_ch_d = channel_q;
          valid_d     = 1'b1;
          // Decide now what follows so done lines up with valid.
          if (higher_found_c) begin
            next_ch_d = higher_ch_c;
          end else if (continuous && (ch_mask != '0)) begin
            mask_d    = ch_mask;
            next_ch_d = lowest_ch(ch_mask);
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_STORE: begin
        if (state_d == S_SAMPLE) begin
          channel_d = next_ch_q;
          value_d   = MSB;
          pos_d     = MSB;
          sample_d  = 1'b1;
          cnt_d     = CNT_W'(SETTLE);
        end
      end
      default: ;
    endcase

    // Quiet the analog drive whenever the controller is idle.
    if (state_d == S_IDLE) begin
      value_d  = '0;
      sample_d = 1'b0;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      go_q        <= 1'b0;
      mask_q      <= '0;
      next_ch_q   <= '0;
      cnt_q       <= '0;
      pos_q       <= '0;
      value_q     <= '0;
      sample_q    <= 1'b0;
      channel_q   <= '0;
      busy_q      <= 1'b0;
      result_q    <= '0;
      result_ch_q <= '0;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      go_q        <= go_d;
      mask_q      <= mask_d;
      next_ch_q   <= next_ch_d;
      cnt_q       <= cnt_d;
      pos_q       <= pos_d;
      value_q     <= value_d;
      sample_q    <= sample_d;
      channel_q   <= channel_d;
      busy_q      <= busy_d;
      result_q    <= result_d;
      result_ch_q <= result_ch_d;
      valid_q     <= valid_d;
      done_q      <= done_d;
    end
  end

  assign value     = value_q;
  assign sample    = sample_q;
  assign channel   = channel_q;
  assign busy      = busy_q;
  assign result    = result_q;
  assign result_ch = result_ch_q;
  assign valid     = valid_q;
  assign done      = done_q;

endmodule

// File: doc/sar_scan_control.md
Name: sar_scan_control

Overview:
Parametrised successive-approximation ADC controller with a multi-channel scan sequencer.
- Drives the DAC trial word and the sample/hold strobe.
- Reads a single comparator bit and walks a channel mask, producing one tagged result per enabled channel.
- Supports single-scan and continuous-scan modes plus a synchronous abort. Sits between the analog front end (mux, S/H, DAC, comparator) and the register/readout logic.

Parameters:
WIDTH, 16, result and DAC word width in bits (>=2)
SETTLE, 4, sample/hold acquisition length in clock cycles (>=1)
CHANNELS, 4, number of analog input channels (>=1)
CH_BITS, 2, width of channel index, ceil(log2(CHANNELS)), minimum 1

Ports:
clk  input  1  system clock, all logic on rising edge
reset_n  input  1  asynchronous, active-low reset
go  input  1  start request; only the rising edge is acted upon (internal edge detector)
ch_mask  input  CHANNELS  enabled channels; latched on start and on each continuous restart
continuous  input  1  1 = restart scan after last channel; sampled at end of each scan
abort  input  1  synchronous abort, level-sensitive
cmp  input  1  comparator: 1 = DAC trial value exceeds input (trial bit must be cleared)
value  output  WIDTH  DAC trial word
sample  output  1  sample/hold strobe
channel  output  CH_BITS  analog mux select for current conversion
busy  output  1  high in any state except IDLE
result  output  WIDTH  last completed conversion, held until next completion
result_ch  output  CH_BITS  channel of result
valid  output  1  one-cycle pulse when result/result_ch update
done  output  1  one-cycle pulse at end of a non-continuous scan

Behaviour:
- Reset (reset_n=0, async): state IDLE. value=0, sample=0, channel=0, busy=0, result=0, result_ch=0, valid=0, done=0. Edge detector history=0, latched mask=0.
- Start edge = go & ~go_q. go_q is registered every cycle in every state.
- States: IDLE, SAMPLE, CONVERT, STORE.
- IDLE:
  - On start edge with ch_mask!=0: latch mask; channel=lowest set bit; value=1<<(WIDTH-1); pos=same; sample=1; settle counter=SETTLE; go to SAMPLE.
  - Start edge with ch_mask==0: ignored, stay IDLE.
- SAMPLE: counter decrements each cycle. After exactly SETTLE cycles in SAMPLE: sample=0, go to CONVERT. value holds the MSB trial throughout.
- CONVERT: one bit per cycle.
  - If cmp=1, clear bit pos in value.
  - Then pos>>=1; if pos!=0, set new pos bit in value.
  - The cycle that resolves bit 0 goes to STORE. Exactly WIDTH cycles in CONVERT.
- STORE (1 cycle):
  - result<=value, result_ch<=channel, valid=1.
  - If a higher enabled channel remains in the latched mask: select it, reload MSB trial, sample=1, SAMPLE.
  - Else if continuous=1 and ch_mask!=0: relatch ch_mask, lowest channel, SAMPLE.
  - Else: done=1, IDLE.
- Latency: start edge sampled at edge N → sample high N+1..N+SETTLE, CONVERT N+SETTLE+1..N+SETTLE+WIDTH, valid at N+SETTLE+WIDTH+1. Per-channel period = SETTLE+WIDTH+1 cycles, back-to-back with no gap.
- go edges while busy: ignored (not queued).
- ch_mask changes mid-scan: no effect until next start/restart.
- abort=1 in any non-IDLE state: next cycle IDLE, sample=0, value=0. No valid, no done. result/result_ch keep their old values. abort in IDLE: no effect. abort with start edge in the same cycle from IDLE: abort wins, stay IDLE.
- continuous dropped mid-scan: current scan completes, done pulses at its end.
- reset_n asserted mid-conversion: immediate return to reset values.
- value is all zeros in IDLE.

Test Plan:
1. WIDTH=8, SETTLE=2, mask=4'b0001, comparator model cmp=(value>vin), vin=0xA5, single go pulse → sample high 2 cycles, value sequence 0x80,0xC0,0xA0,0xB0,0xA8,0xA4,0xA6,0xA5. Valid 11 cycles after the go edge with result=0xA5, result_ch=0, done same cycle, busy low next cycle.
2. mask=4'b1010, vin1=0x00, vin3=0xFF → valid pulses 11 cycles apart: result=0x00/ch 1, then 0xFF/ch 3. done only with the second valid. Channel 0 and 2 are never selected.
3. continuous=1, mask=4'b0011 → valid every 11 cycles cycling ch 0,1,0,1…, no done. Drop continuous during a ch-0 conversion → ch-1 result, then done, then IDLE.
4. Assert abort during CONVERT → IDLE next cycle, value=0, no valid/done, result unchanged. New go edge → normal conversion.
5. go held high for 40 cycles, plus extra go edges while busy, and a go edge with mask=0 → exactly one conversion for the first edge. Mask-0 edge leaves busy=0.
6. reset_n low mid-SAMPLE and mid-CONVERT, with asynchronous timing (not aligned to clk) → all outputs at reset values immediately. After release, go edge gives correct conversion.
